// File: rtl/mem_arbiter.sv
// Two-requester (CPU / DMA) arbiter and sequencer for the single-port system RAM.
// Define ARB_ROUND_ROBIN_EN to break CPU/DMA ties round-robin instead of CPU-first.
module mem_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CpuReq,
    input  logic              CpuWe,
    input  logic [ADDR_W-1:0] CpuAddr,
    input  logic [DATA_W-1:0] CpuWData,
    output logic              CpuAck,
    output logic [DATA_W-1:0] CpuRData,
    input  logic              DmaReq,
    input  logic              DmaWe,
    input  logic [ADDR_W-1:0] DmaAddr,
    input  logic [DATA_W-1:0] DmaWData,
    output logic              DmaAck,
    output logic [DATA_W-1:0] DmaRData,
    output logic              MemEn,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    output logic              Busy,
    output logic              GntDma
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

    state_t              state;
    state_t              next_state;
    logic [1:0]          lat_cnt;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                grant;
    logic                win_dma;
`ifdef ARB_ROUND_ROBIN_EN
    logic                last_dma;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Memory strobes and acks are decoded from the state so that reset kills them at once.
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        win_dma    = 1'b0;
        MemEn      = 1'b0;
        MemWe      = 1'b0;
        Busy       = 1'b1;
        CpuAck     = 1'b0;
        DmaAck     = 1'b0;
        case (state)
            IDLE: begin
                Busy = 1'b0;
                if (CpuReq || DmaReq) begin
                    grant      = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    win_dma    = DmaReq && (!CpuReq || !last_dma);
`else
                    win_dma    = DmaReq && !CpuReq;
`endif
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                MemEn      = 1'b1;
                MemWe      = lat_we;
                next_state = lat_we ? DONE : WAIT;
            end
            WAIT: begin
                if (lat_cnt == 2'd0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                CpuAck     = !GntDma;
                DmaAck     = GntDma;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign MemAddr  = lat_addr;
    assign MemWData = lat_wdata;

    // Request fields are captured only at grant, so requesters may change them mid-access.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            lat_cnt   <= 2'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            GntDma    <= 1'b0;
            CpuRData  <= '0;
            DmaRData  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_dma  <= 1'b1;
`endif
        end else begin
            if (grant) begin
                GntDma    <= win_dma;
                lat_we    <= win_dma ? DmaWe : CpuWe;
                lat_addr  <= win_dma ? DmaAddr : CpuAddr;
                lat_wdata <= win_dma ? DmaWData : CpuWData;
`ifdef ARB_ROUND_ROBIN_EN
                last_dma  <= win_dma;
`endif
            end
            if (state == ISSUE) begin
                lat_cnt <= LAT_INIT;
            end
            if (state == WAIT) begin
                if (lat_cnt == 2'd0) begin
                    if (GntDma) begin
                        DmaRData <= MemRData;
                    end else begin
                        CpuRData <= MemRData;
                    end
                end else begin
                    lat_cnt <= lat_cnt - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance with MEM_LAT=1 (index 0), one with MEM_LAT=3 (index 1).
// Tie-order expectations follow ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_mem_arbiter;

    typedef struct {
        bit          dma;
        bit          rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        rst [2];
    logic        req [2][2];
    logic        wen [2][2];
    logic [8:0]  addr [2][2];
    logic [31:0] wdata [2][2];

    logic        cpu_ack_a, dma_ack_a, mem_en_a, mem_we_a, busy_a, gnt_dma_a;
    logic [31:0] cpu_rdata_a, dma_rdata_a, mem_wdata_a, mem_rdata_a;
    logic [8:0]  mem_addr_a;
    logic        cpu_ack_b, dma_ack_b, mem_en_b, mem_we_b, busy_b, gnt_dma_b;
    logic [31:0] cpu_rdata_b, dma_rdata_b, mem_wdata_b, mem_rdata_b;
    logic [8:0]  mem_addr_b;

    logic        ld_en_a = 1'b0;
    logic        ld_en_b = 1'b0;
    logic [8:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] ram_a [512];
    logic [31:0] ram_b [512];
    logic [31:0] rd_a, p1_b, p2_b, p3_b;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q_a[$];
    exp_t        q_b[$];
    int          men_cnt [2];
    int          men_cyc [2];
    logic [8:0]  men_addr [2];
    logic        men_we [2];
    logic [31:0] men_wd [2];

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    mem_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(1)) dut_a (
        .Clock(Clock), .Reset(rst[0]),
        .CpuReq(req[0][0]), .CpuWe(wen[0][0]), .CpuAddr(addr[0][0]), .CpuWData(wdata[0][0]),
        .CpuAck(cpu_ack_a), .CpuRData(cpu_rdata_a),
        .DmaReq(req[0][1]), .DmaWe(wen[0][1]), .DmaAddr(addr[0][1]), .DmaWData(wdata[0][1]),
        .DmaAck(dma_ack_a), .DmaRData(dma_rdata_a),
        .MemEn(mem_en_a), .MemWe(mem_we_a), .MemAddr(mem_addr_a), .MemWData(mem_wdata_a),
        .MemRData(mem_rdata_a), .Busy(busy_a), .GntDma(gnt_dma_a)
    );

    mem_arbiter #(.ADDR_W(9), .DATA_W(32), .MEM_LAT(3)) dut_b (
        .Clock(Clock), .Reset(rst[1]),
        .CpuReq(req[1][0]), .CpuWe(wen[1][0]), .CpuAddr(addr[1][0]), .CpuWData(wdata[1][0]),
        .CpuAck(cpu_ack_b), .CpuRData(cpu_rdata_b),
        .DmaReq(req[1][1]), .DmaWe(wen[1][1]), .DmaAddr(addr[1][1]), .DmaWData(wdata[1][1]),
        .DmaAck(dma_ack_b), .DmaRData(dma_rdata_b),
        .MemEn(mem_en_b), .MemWe(mem_we_b), .MemAddr(mem_addr_b), .MemWData(mem_wdata_b),
        .MemRData(mem_rdata_b), .Busy(busy_b), .GntDma(gnt_dma_b)
    );

    // RAM models: one-cycle read for instance a, three-stage read pipeline for instance b.
    always @(posedge Clock) begin
        if (ld_en_a) ram_a[ld_addr] <= ld_data;
        else if (mem_en_a && mem_we_a) ram_a[mem_addr_a] <= mem_wdata_a;
        if (mem_en_a && !mem_we_a) rd_a <= ram_a[mem_addr_a];
        if (ld_en_b) ram_b[ld_addr] <= ld_data;
        else if (mem_en_b && mem_we_b) ram_b[mem_addr_b] <= mem_wdata_b;
        if (mem_en_b && !mem_we_b) p1_b <= ram_b[mem_addr_b];
        p2_b <= p1_b;
        p3_b <= p2_b;
    end
    assign mem_rdata_a = rd_a;
    assign mem_rdata_b = p3_b;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, required 0x%08h", name, cyc, act, req_v);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req_v);
        check_output(name, 32'(act), 32'(req_v));
    endtask

    function automatic logic ack_of(input int d, input int p);
        if (d == 0) return (p == 1) ? dma_ack_a : cpu_ack_a;
        return (p == 1) ? dma_ack_b : cpu_ack_b;
    endfunction

    function automatic logic [31:0] rdata_of(input int d, input int p);
        if (d == 0) return (p == 1) ? dma_rdata_a : cpu_rdata_a;
        return (p == 1) ? dma_rdata_b : cpu_rdata_b;
    endfunction

    task automatic push_exp(input int d, input bit dma, input bit rd, input logic [31:0] data, input int c);
        exp_t e;
        e.dma = dma; e.rd = rd; e.data = data; e.cyc = c;
        if (d == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endtask

    task automatic sb_check(input int d);
        exp_t e;
        logic dack;
        dack = ack_of(d, 1);
        check_bit("ack_exclusive", ack_of(d, 0) & dack, 1'b0);
        if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_ack dut %0d at cycle %0d: got cpu=%0b dma=%0b, required no ack",
                     d, cyc, ack_of(d, 0), dack);
        end else begin
            e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
            check_bit("ack_port", dack, e.dma);
            check_output("ack_cycle", cyc, e.cyc);
            if (e.rd) check_output("rdata", rdata_of(d, e.dma ? 1 : 0), e.data);
        end
    endtask

    // Monitor: compares every ack against the scoreboard and records each MemEn pulse.
    always @(negedge Clock) begin
        if (cpu_ack_a || dma_ack_a) sb_check(0);
        if (cpu_ack_b || dma_ack_b) sb_check(1);
        if (mem_en_a) begin
            men_cnt[0]++; men_cyc[0] = cyc; men_addr[0] = mem_addr_a;
            men_we[0] = mem_we_a; men_wd[0] = mem_wdata_a;
        end
        if (mem_en_b) begin
            men_cnt[1]++; men_cyc[1] = cyc; men_addr[1] = mem_addr_b;
            men_we[1] = mem_we_b; men_wd[1] = mem_wdata_b;
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_ack(input int d, input int p);
        int n;
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!ack_of(d, p) && n < 20);
        check_bit("ack_seen", ack_of(d, p), 1'b1);
    endtask

    task automatic load(input int d, input logic [8:0] a, input logic [31:0] v);
        ld_addr = a; ld_data = v;
        if (d == 0) ld_en_a = 1'b1; else ld_en_b = 1'b1;
        step();
        ld_en_a = 1'b0; ld_en_b = 1'b0;
    endtask

    // One access from cycle 0 (now); hold keeps Req up one cycle past Ack for a second access.
    task automatic apply_stimulus(input int d, input int p, input logic w, input logic [8:0] a,
                                  input logic [31:0] wd, input logic [31:0] ex, input bit hold);
        int c0;
        int extra;
        c0 = cyc;
        extra = w ? 0 : ((d == 0) ? 1 : 3);
        req[d][p] = 1'b1; wen[d][p] = w; addr[d][p] = a; wdata[d][p] = wd;
        push_exp(d, p == 1, !w, ex, c0 + 2 + extra);
        if (hold) begin
            wait_ack(d, p);
            step();
            c0 = cyc;
            push_exp(d, p == 1, !w, ex, c0 + 2 + extra);
            step();
            req[d][p] = 1'b0;
        end
        wait_ack(d, p);
        req[d][p] = 1'b0;
        check_output("memen_cycle", men_cyc[d], c0 + 1);
        check_output("mem_addr", 32'(men_addr[d]), 32'(a));
        check_bit("mem_we", men_we[d], w);
        if (w) check_output("mem_wdata", men_wd[d], wd);
        step();
    endtask

    task automatic check_reset_state(input int d);
        if (d == 0) begin
            check_bit("rst_mem_en", mem_en_a, 1'b0);   check_bit("rst_mem_we", mem_we_a, 1'b0);
            check_bit("rst_busy", busy_a, 1'b0);       check_bit("rst_gnt", gnt_dma_a, 1'b0);
            check_bit("rst_cpu_ack", cpu_ack_a, 1'b0); check_bit("rst_dma_ack", dma_ack_a, 1'b0);
            check_output("rst_mem_addr", 32'(mem_addr_a), 32'h0);
            check_output("rst_mem_wdata", mem_wdata_a, 32'h0);
            check_output("rst_cpu_rdata", cpu_rdata_a, 32'h0);
            check_output("rst_dma_rdata", dma_rdata_a, 32'h0);
        end else begin
            check_bit("rst_mem_en", mem_en_b, 1'b0);   check_bit("rst_mem_we", mem_we_b, 1'b0);
            check_bit("rst_busy", busy_b, 1'b0);       check_bit("rst_gnt", gnt_dma_b, 1'b0);
            check_bit("rst_cpu_ack", cpu_ack_b, 1'b0); check_bit("rst_dma_ack", dma_ack_b, 1'b0);
            check_output("rst_mem_addr", 32'(mem_addr_b), 32'h0);
            check_output("rst_mem_wdata", mem_wdata_b, 32'h0);
            check_output("rst_cpu_rdata", cpu_rdata_b, 32'h0);
            check_output("rst_dma_rdata", dma_rdata_b, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        int n;
        int men0;
        int n_cpu;
        int n_dma;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            men_cnt[d] = 0; men_cyc[d] = -1; men_addr[d] = '0; men_we[d] = 1'b0; men_wd[d] = '0;
            for (int p = 0; p < 2; p++) begin
                req[d][p] = 1'b0; wen[d][p] = 1'b0; addr[d][p] = '0; wdata[d][p] = '0;
            end
        end
        #2;
        check_reset_state(0);
        check_reset_state(1);
        load(0, 9'h010, 32'hA5A50010);
        load(0, 9'h020, 32'h5A5A0020);
        load(1, 9'h1FF, 32'h12345678);
        load(1, 9'h002, 32'hCAFEF00D);
        rst[0] = 1'b0; rst[1] = 1'b0;
        step();

        $display("[TB] CPU write then read, MEM_LAT=1");
        apply_stimulus(0, 0, 1'b1, 9'h005, 32'hDEADBEEF, 32'h0, 1'b0);
        apply_stimulus(0, 0, 1'b0, 9'h005, 32'h0, 32'hDEADBEEF, 1'b0);

        $display("[TB] CPU address change after grant");
        c0 = cyc;
        req[0][0] = 1'b1; wen[0][0] = 1'b0; addr[0][0] = 9'h010;
        push_exp(0, 1'b0, 1'b1, 32'hA5A50010, c0 + 3);
        step();
        addr[0][0] = 9'h020;
        n = 0;
        do begin
            @(negedge Clock);
            n++;
            check_output("mem_addr_hold", 32'(mem_addr_a), 32'h010);
        end while (!cpu_ack_a && n < 10);
        check_bit("addr_test_ack", cpu_ack_a, 1'b1);
        req[0][0] = 1'b0;
        check_output("addr_test_memen", men_cyc[0], c0 + 1);
        step();

        $display("[TB] simultaneous requests, two transactions each");
        c0 = cyc;
        push_exp(0, 1'b0, 1'b0, 32'h0, c0 + 2);
        push_exp(0, RR, 1'b0, 32'h0, c0 + 5);
        push_exp(0, !RR, 1'b0, 32'h0, c0 + 8);
        push_exp(0, 1'b1, 1'b0, 32'h0, c0 + 11);
        req[0][0] = 1'b1; wen[0][0] = 1'b1; addr[0][0] = 9'h030; wdata[0][0] = 32'hAAAA0030;
        req[0][1] = 1'b1; wen[0][1] = 1'b1; addr[0][1] = 9'h031; wdata[0][1] = 32'hBBBB0031;
        n_cpu = 0; n_dma = 0;
        for (int k = 0; k < 30 && (req[0][0] || req[0][1]); k++) begin
            @(negedge Clock);
            if (cpu_ack_a) begin n_cpu++; if (n_cpu == 2) req[0][0] = 1'b0; end
            if (dma_ack_a) begin n_dma++; if (n_dma == 2) req[0][1] = 1'b0; end
        end
        check_output("arb_cpu_acks", n_cpu, 2);
        check_output("arb_dma_acks", n_dma, 2);
        req[0][0] = 1'b0; req[0][1] = 1'b0;
        step();
        apply_stimulus(0, 0, 1'b0, 9'h030, 32'h0, 32'hAAAA0030, 1'b0);
        apply_stimulus(0, 1, 1'b0, 9'h031, 32'h0, 32'hBBBB0031, 1'b0);
        check_output("cpu_rdata_kept", cpu_rdata_a, 32'hAAAA0030);

        $display("[TB] Req held one cycle past Ack");
        men0 = men_cnt[0];
        apply_stimulus(0, 0, 1'b1, 9'h040, 32'h11112222, 32'h0, 1'b1);
        check_output("held_memen_pulses", men_cnt[0] - men0, 2);
        check_output("write_keeps_cpu_rdata", cpu_rdata_a, 32'hAAAA0030);
        check_output("write_keeps_dma_rdata", dma_rdata_a, 32'hBBBB0031);

        $display("[TB] MEM_LAT=3 reads");
        apply_stimulus(1, 0, 1'b0, 9'h002, 32'h0, 32'hCAFEF00D, 1'b0);
        apply_stimulus(1, 1, 1'b0, 9'h1FF, 32'h0, 32'h12345678, 1'b0);
        check_output("lat3_cpu_rdata_kept", cpu_rdata_b, 32'hCAFEF00D);

        $display("[TB] reset during WAIT of a DMA read");
        req[1][1] = 1'b1; wen[1][1] = 1'b0; addr[1][1] = 9'h1FF;
        step(); step(); step();
        check_bit("busy_in_wait", busy_b, 1'b1);
        rst[1] = 1'b1;
        req[1][1] = 1'b0;
        #1;
        check_reset_state(1);
        step(); step(); step();
        rst[1] = 1'b0;
        step();
        apply_stimulus(1, 1, 1'b0, 9'h1FF, 32'h0, 32'h12345678, 1'b0);

        step(); step();
        check_output("queue_empty", 32'(q_a.size() + q_b.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single-port synchronous system RAM. It sits between the memory side of the processor (MAR/MDR read/write path driven by the control unit) and a DMA/loader port. It serialises their accesses, drives the RAM, and returns read data with a one-cycle acknowledge pulse. It also absorbs the RAM read latency, so the control unit can hold its Read/Write step until acknowledge.

## Interface
Parameters:
- ADDR_W, 9: word address width (512-word RAM).
- DATA_W, 32: data width.
- MEM_LAT, 1: RAM read latency in cycles, measured from the MemEn cycle to valid MemRData. Legal values are 1..3.

Ports:
- Clock  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- CpuReq  in  1  CPU access request; held high until CpuAck.
- CpuWe  in  1  1 = write, 0 = read; stable while CpuReq is high.
- CpuAddr  in  ADDR_W  CPU word address.
- CpuWData  in  DATA_W  CPU write data.
- CpuAck  out  1  one-cycle completion pulse.
- CpuRData  out  DATA_W  registered read data; valid from CpuAck and held until the next CPU read completes.
- DmaReq, DmaWe, DmaAddr, DmaWData, DmaAck, DmaRData: same as the Cpu* ports, for the DMA port.
- MemEn  out  1  RAM enable, one cycle per access.
- MemWe  out  1  RAM write enable; qualified by MemEn.
- MemAddr  out  ADDR_W  RAM address.
- MemWData  out  DATA_W  RAM write data.
- MemRData  in  DATA_W  RAM read data.
- Busy  out  1  high in any state other than IDLE.
- GntDma  out  1  owner of the current or most recent transaction: 0 = CPU, 1 = DMA.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - Samples CpuReq and DmaReq.
  - If either is high: latch the winner's We, Addr and WData, set GntDma, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE
  - MemEn = 1; MemWe, MemAddr and MemWData come from the latched values.
  - Write: go to DONE.
  - Read: go to WAIT with the latency counter loaded to MEM_LAT-1.
- WAIT
  - Counter decrements each cycle.
  - When the counter is 0: capture MemRData into the granted requester's RData register, then go to DONE.
- DONE
  - Assert the granted requester's Ack for exactly one cycle, then go to IDLE.
- Arbitration (default): fixed priority, CPU over DMA.
- Request handshake:
  - A requester must drop Req no later than the cycle after its Ack.
  - If Req is still high when IDLE samples it, it is a new transaction.
- The non-granted requester keeps Req high and waits; no request is lost.
- The Addr, We and WData ports are sampled only in IDLE. Changes after the grant have no effect on the current access.
- An RData register updates only on a read completion for its own port. Writes never alter RData.
- The two Ack outputs are never high in the same cycle.

## Timing
- Reset values:
  - State IDLE; latency counter 0; GntDma 0 (round-robin pointer: DMA last-granted).
  - CpuAck, DmaAck, MemEn, MemWe and Busy all 0.
  - MemAddr, MemWData, CpuRData and DmaRData all 0.
- Reset asserted mid-transaction:
  - Outputs go to their reset values immediately (asynchronously) and the access is abandoned with no Ack.
  - A write whose ISSUE cycle is cut by reset before the clock edge is not committed.
- Latency, with Req high in cycle 0 (sampled at the end of cycle 0):
  - Write: MemEn in cycle 1; Ack in cycle 2.
  - Read: MemEn in cycle 1; RData captured at the end of cycle 1+MEM_LAT; Ack and valid RData in cycle 2+MEM_LAT. With MEM_LAT=1 that is cycle 3.
- Back-to-back: the minimum spacing between MemEn pulses is 3 cycles for writes and 3+MEM_LAT cycles for reads, because IDLE costs one cycle.
- Busy is high from cycle 1 through the Ack cycle.

## Configuration
- ARB_ROUND_ROBIN_EN
  - Defined: on simultaneous requests in IDLE, grant the port that was not granted last. The last-granted pointer updates on every grant and resets to DMA, so the CPU wins the first tie.
  - Undefined: fixed priority, CPU over DMA; a CPU that keeps requesting can starve the DMA port indefinitely.
  - In both modes, a lone requester is always granted.

## Test plan
- CPU write 0xDEADBEEF to address 0x05, then CPU read of 0x05 with MEM_LAT=1 -> MemEn in cycle 1, CpuAck in cycle 2 (write); CpuAck in cycle 3 of the read with CpuRData=0xDEADBEEF; DmaAck never asserts.
- DMA read of 0x1FF with MEM_LAT=3 and RAM preloaded with 0x12345678 -> DmaAck 5 cycles after the sample cycle, DmaRData=0x12345678, CpuRData unchanged.
- CpuReq and DmaReq rise in the same cycle and both are held for two transactions:
  - Without the macro: order CPU, CPU, ...; the DMA port waits until CPU drops Req.
  - With ARB_ROUND_ROBIN_EN: order CPU, DMA, CPU.
- During a read, change CpuAddr from 0x10 to 0x20 after the grant -> MemAddr stays 0x10 for the entire access.
- Assert Reset in the WAIT state of a DMA read -> MemEn, Busy and Ack go to 0 immediately, the FSM is in IDLE, no DmaAck occurs, DmaRData=0.
- Requester holds Req high for one cycle after Ack -> it is treated as a second transaction, giving a second Ack and exactly two MemEn pulses.
